// File: rtl/dds_phase_acc.sv
// DDS phase accumulator with phase offset, carry pulse and linear frequency sweep.
// Ports: clk, rst (sync, active high), en, fword/pword + load, phase_clr,
//        sweep_en/sweep_step/sweep_stop/sweep_div; outputs addr, wrap, valid, cur_fword.
module dds_phase_acc #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ACC_W-1:0]  fword,
    input  logic [ACC_W-1:0]  pword,
    input  logic              load,
    input  logic              phase_clr,
    input  logic              sweep_en,
    input  logic [ACC_W-1:0]  sweep_step,
    input  logic [ACC_W-1:0]  sweep_stop,
    input  logic [DIV_W-1:0]  sweep_div,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap,
    output logic              valid,
    output logic [ACC_W-1:0]  cur_fword
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = 1;

    state_t state;
    state_t state_nxt;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  f_act;
    logic [ACC_W-1:0]  p_act;
    logic [ACC_W-1:0]  f_start;
    logic [DIV_W-1:0]  div_cnt;

    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  phase_sum;
    logic [ACC_W:0]    step_sum;
    logic              step_ovf;
    logic              sweep_tick;
    logic              step_hit;
    logic              sweep_exit;

    logic [ACC_W-1:0]  acc_nxt;
    logic              wrap_nxt;
    logic [ACC_W-1:0]  f_act_nxt;
    logic [ACC_W-1:0]  p_act_nxt;
    logic [ACC_W-1:0]  f_start_nxt;
    logic [DIV_W-1:0]  div_cnt_nxt;

    // Carry-out of the accumulator add is the wrap indication.
    assign acc_sum   = {1'b0, acc} + {1'b0, f_act};
    assign phase_sum = acc + p_act;

    // Extra bit on the step sum catches tuning-word overflow.
    assign step_sum  = {1'b0, f_act} + {1'b0, sweep_step};
    assign step_ovf  = step_sum[ACC_W] || (step_sum > {1'b0, sweep_stop});

    // Stepping only while the FSM stays in SWEEP; the exit cycle holds f_act.
    assign sweep_tick = (state == SWEEP) && sweep_en && en;
    assign step_hit   = sweep_tick && (div_cnt == sweep_div);
    assign sweep_exit = (state == SWEEP) && !sweep_en;

    assign cur_fword = f_act;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sweep_en)  state_nxt = SWEEP;
            SWEEP:   if (!sweep_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_nxt  = acc;
        wrap_nxt = 1'b0;
        if (phase_clr) begin
            acc_nxt  = '0;
            wrap_nxt = 1'b0;
        end else if (en) begin
            acc_nxt  = acc_sum[ACC_W-1:0];
            wrap_nxt = acc_sum[ACC_W];
        end
    end

    always_comb begin
        f_act_nxt   = f_act;
        p_act_nxt   = p_act;
        f_start_nxt = f_start;
        div_cnt_nxt = div_cnt;
        if (load) begin
            f_act_nxt   = fword;
            p_act_nxt   = pword;
            f_start_nxt = fword;
            div_cnt_nxt = '0;
        end else if (sweep_exit) begin
            div_cnt_nxt = '0;
        end else if (step_hit) begin
            div_cnt_nxt = '0;
            f_act_nxt   = step_ovf ? f_start : step_sum[ACC_W-1:0];
        end else if (sweep_tick) begin
            div_cnt_nxt = div_cnt + DIV_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            f_act   <= '0;
            p_act   <= '0;
            f_start <= '0;
            div_cnt <= '0;
            addr    <= '0;
            wrap    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            f_act   <= f_act_nxt;
            p_act   <= p_act_nxt;
            f_start <= f_start_nxt;
            div_cnt <= div_cnt_nxt;
            addr    <= phase_sum[ACC_W-1 -: ADDR_W];
            wrap    <= wrap_nxt;
            valid   <= en;
        end
    end

endmodule
